// File: rtl/ram_sp_param.sv
// Single-port byte-maskable RAM with selectable read-during-write behaviour,
// optional output register and a background whole-array clear engine.
module ram_sp_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    write_en,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    input  logic                    clear_req,
    output logic                    busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("ram_sp_param: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
        $error("ram_sp_param: RDW_MODE must be 0, 1 or 2");
    end

    // state    | meaning
    // ST_IDLE  | normal read/write access
    // ST_CLEAR | zeroing one word per cycle, accesses ignored
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_vld;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_access;
    logic                    w_write;

    // a clear request wins over an access presented in the same cycle
    assign w_access  = (r_state == ST_IDLE) && en && !clear_req;
    assign w_write   = w_access && write_en;
    assign w_rd_word = r_mem[address];
    assign busy      = (r_state == ST_CLEAR);

    always_comb begin
        w_merged = w_rd_word;
        for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
                w_merged[8*k +: 8] = data_in[8*k +: 8];
            end
        end
    end

    // array has no reset so its contents survive reset and aborted clears
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_write) begin
            r_mem[address] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= 1'b0;
            if (w_access) begin
                if (!write_en || RDW_MODE == 0) begin
                    r_rd_data <= w_rd_word;
                    r_rd_vld  <= 1'b1;
                end else if (RDW_MODE == 1) begin
                    r_rd_data <= w_merged;
                    r_rd_vld  <= 1'b1;
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_out_data;
        logic                  r_out_vld;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_out_data <= '0;
                r_out_vld  <= 1'b0;
            end else begin
                r_out_data <= r_rd_data;
                r_out_vld  <= r_rd_vld;
            end
        end

        assign data_out = r_out_data;
        assign rd_valid = r_out_vld;
    end else begin : g_no_out_reg
        assign data_out = r_rd_data;
        assign rd_valid = r_rd_vld;
    end

endmodule

// File: doc/ram_sp_param.md
RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits; it SHALL be a multiple of 8, otherwise elaboration fails.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter RDW_MODE, default 0, read-during-write mode: 0 read-first, 1 write-first, 2 no-change; other values fail elaboration.
REQ-004 The block SHALL have parameter OUT_REG, default 0, which adds an optional output register stage: 0 gives read latency 1, 1 gives read latency 2.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit, access enable.
REQ-008 The block SHALL have port write_en, input, 1 bit: 1 means write, 0 means read; valid when en=1.
REQ-009 The block SHALL have port byte_en, input, DATA_WIDTH/8 bits, per-byte write mask; bit k covers data bits [8k+7:8k].
REQ-010 The block SHALL have port address, input, ADDR_WIDTH bits, word address.
REQ-011 The block SHALL have port data_in, input, DATA_WIDTH bits, write data.
REQ-012 The block SHALL have port data_out, output, DATA_WIDTH bits, read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit, a one-cycle pulse marking new data_out.
REQ-014 The block SHALL have port clear_req, input, 1 bit, request to zero the whole array.
REQ-015 The block SHALL have port busy, output, 1 bit, high while the clear engine runs.

Function
REQ-016 The FSM SHALL have two states, IDLE and CLEAR; busy SHALL be 1 exactly when the state is CLEAR.
REQ-017 In IDLE, a read (en=1, write_en=0) SHALL place mem[address] on data_out after the configured latency, with rd_valid=1 in that same cycle.
REQ-018 In IDLE, a write (en=1, write_en=1) SHALL update only the bytes whose byte_en bit is 1; the other bytes SHALL be unchanged; byte_en=0 SHALL leave the word unchanged.
REQ-019 On a write with RDW_MODE=0, data_out SHALL return the pre-write word and rd_valid SHALL pulse.
REQ-020 On a write with RDW_MODE=1, data_out SHALL return the post-write merged word and rd_valid SHALL pulse.
REQ-021 On a write with RDW_MODE=2, data_out SHALL hold its value and rd_valid SHALL be 0.
REQ-022 When en=0, data_out SHALL hold its value and rd_valid SHALL be 0 at the corresponding latency slot.
REQ-023 With OUT_REG=1, data_out and rd_valid SHALL both be delayed one extra cycle, and back-to-back reads SHALL sustain one result per cycle.
REQ-024 clear_req=1 sampled in IDLE SHALL move the FSM to CLEAR with the clear pointer at 0; an access presented in that same cycle SHALL be dropped, with no write and no rd_valid.
REQ-025 In CLEAR, each cycle SHALL write zero to mem[pointer] and increment the pointer; after writing DEPTH-1 the FSM SHALL return to IDLE, so busy is high for exactly DEPTH cycles.
REQ-026 While busy=1, en and clear_req SHALL be ignored, and rd_valid SHALL be 0 for accesses attempted during CLEAR.
REQ-027 Reads issued before the clear started SHALL still complete normally through the OUT_REG stage.
REQ-028 The clear pointer SHALL be ADDR_WIDTH+1 bits wide or terminate by compare, so that no wrap-around restart occurs.

Reset
REQ-029 reset=0 SHALL asynchronously force the following: FSM to IDLE, busy=0, clear pointer=0, data_out=0, rd_valid=0, and all pipeline registers to 0.
REQ-030 Array contents SHALL NOT be altered by reset; an asserted reset in mid-clear SHALL abort the clear, leaving words cleared so far at 0 and the rest unchanged.
REQ-031 The first access SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 Scenario: DATA_WIDTH=32; write addr 5 = 0xAABBCCDD with byte_en=1111, then write addr 5 = 0x11223344 with byte_en=0101, then read addr 5 -> data_out=0xAA22CC44 and rd_valid=1 one cycle after the read.
REQ-033 Scenario: addr 3 = 0x55; write 0x66 to addr 3 in each RDW_MODE -> mode 0 gives data_out 0x55 with rd_valid=1; mode 1 gives 0x66 with rd_valid=1; mode 2 holds the prior data_out with rd_valid=0.
REQ-034 Scenario: OUT_REG=1; read addrs 0,1,2 on consecutive cycles -> three rd_valid pulses in cycles 2,3,4 carrying mem[0..2] in order.
REQ-035 Scenario: ADDR_WIDTH=4; pulse clear_req together with a write to addr 7 -> busy high for exactly 16 cycles, addr 7 not written, and every address then reads 0.
REQ-036 Scenario: assert reset during CLEAR at pointer 6 -> busy=0 and data_out=0 immediately; addrs 0-5 read 0 and addrs 6-15 keep their old data.
REQ-037 Scenario: en=1 reads during busy -> no rd_valid; the same read after busy falls returns correct data.
